// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: size encodings, FSM state
// encoding and the byte-lane helpers used by the store path.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StWait = 2'd1;
  localparam state_t StResp = 2'd2;

  // Lanes touched by an access of the given size at the given byte offset.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SIZE_B:  be = 4'b0001 << off;
      SIZE_H:  be = off[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data so every candidate lane carries it.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (size)
      SIZE_B:  lanes = {4{wdata[7:0]}};
      SIZE_H:  lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response handshakes between datapath and data memory.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Word-organised synchronous RAM with per-byte write enable and registered read.
// The read register only updates on a load, so it holds the last loaded word.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned Aw = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [Aw-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Byte-masked write or registered read, one per enabled cycle.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store with lane steering, sign
// extension and fault detection. Define DMEM_WAIT_EN to insert WAIT_CYCLES wait
// states before each non-faulting access.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned Aw = $clog2(DEPTH_WORDS);

  if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0 || DEPTH_WORDS < 2) begin : g_bad_depth
    $error("DEPTH_WORDS must be a power of two >= 2");
  end
  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be 0..15");
  end

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        uns_q, uns_d;
  logic        err_q, err_d;
`ifdef DMEM_WAIT_EN
  logic [3:0]    cnt_q, cnt_d;
  logic [Aw-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
`endif

  logic          ram_en, ram_we;
  logic [3:0]    ram_be;
  logic [Aw-1:0] ram_idx;
  logic [31:0]   ram_wdata, ram_rdata;
  logic          req_err, accept;

  assign req_err = (bus.req_size == 2'b11) ||
                   (bus.req_size == SIZE_H && bus.req_addr[0]) ||
                   (bus.req_size == SIZE_W && bus.req_addr[1:0] != 2'b00) ||
                   ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS));

  assign bus.req_ready = (state_q == StIdle) && !rst;
  assign accept        = bus.req_ready && bus.req_valid;

  // Next-state, request capture and RAM access selection.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    off_d     = off_q;
    uns_d     = uns_q;
    err_d     = err_q;
`ifdef DMEM_WAIT_EN
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
`endif
    // Default to the live request so the zero-wait path can access on accept.
    ram_en    = 1'b0;
    ram_we    = bus.req_we;
    ram_be    = byte_en(bus.req_size, bus.req_addr[1:0]);
    ram_idx   = bus.req_addr[Aw+1:2];
    ram_wdata = store_lanes(bus.req_size, bus.req_wdata);

    case (state_q)
      StIdle: begin
        if (accept) begin
          we_d   = bus.req_we;
          size_d = bus.req_size;
          off_d  = bus.req_addr[1:0];
          uns_d  = bus.req_unsigned;
          err_d  = req_err;
`ifdef DMEM_WAIT_EN
          idx_d   = bus.req_addr[Aw+1:2];
          wdata_d = bus.req_wdata;
          if (req_err) begin
            state_d = StResp;
          end else if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            ram_en  = 1'b1;
            state_d = StResp;
          end
`else
          ram_en  = !req_err;
          state_d = StResp;
`endif
        end
      end
`ifdef DMEM_WAIT_EN
      StWait: begin
        if (cnt_q == 4'd0) begin
          ram_en    = !rst;
          ram_we    = we_q;
          ram_be    = byte_en(size_q, off_q);
          ram_idx   = idx_q;
          ram_wdata = store_lanes(size_q, wdata_q);
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and captured request fields, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      size_q  <= SIZE_B;
      off_q   <= 2'b00;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef DMEM_WAIT_EN
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      off_q   <= off_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
`ifdef DMEM_WAIT_EN
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
`endif
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clk),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .be_i   (ram_be),
    .idx_i  (ram_idx),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  logic [31:0] shifted, load_ext;

  // Load lane steering and extension; outputs read zero outside a good load.
  always_comb begin
    shifted = ram_rdata >> {off_q, 3'b000};
    case (size_q)
      SIZE_B:  load_ext = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_H:  load_ext = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
    bus.rsp_valid = (state_q == StResp);
    bus.rsp_err   = (state_q == StResp) && err_q;
    bus.rsp_rdata = ((state_q == StResp) && !err_q && !we_q) ? load_ext : 32'h0;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-addressed
// reference memory.
module tb_dmem_responder;
  localparam int unsigned Depth = 1024;
  localparam int unsigned Waits = 2;
`ifdef DMEM_WAIT_EN
  localparam int ExpLat = 1 + Waits;
`else
  localparam int ExpLat = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS(Depth),
    .WAIT_CYCLES(Waits)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_total = 0;
  int n_bad   = 0;
  logic [7:0] mem_b [4*Depth];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic ref_err(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'd3) return 1'b1;
    if (addr % nbytes(size) != 0) return 1'b1;
    return (addr / 4) >= Depth;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                           input logic uns);
    longint v = 0;
    int n = nbytes(size);
    for (int i = 0; i < n; i++) v += longint'(mem_b[addr + i]) << (8 * i);
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wdata);
    for (int i = 0; i < nbytes(size); i++) mem_b[addr + i] = wdata[8*i +: 8];
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata);
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
  endtask

  // Issue one request, wait for the accept, return latency to rsp_valid (bounded).
  task automatic start_req(input string tag, input logic we, input logic [31:0] addr,
                           input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                           output int lat);
    int t = 0;
    @(negedge clk);
    drive_req(we, addr, size, uns, wdata);
    while (!bus.req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, "/req_ready"}, 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          lat;
    exp_err = ref_err(addr, size);
    exp_rd  = (we || exp_err) ? 32'h0 : ref_load(addr, size, uns);
    start_req(tag, we, addr, size, uns, wdata, lat);
    check({tag, "/lat"}, 32'(lat), 32'(ExpLat));
    check({tag, "/err"}, 32'(bus.rsp_err), 32'(exp_err));
    check({tag, "/rdata"}, bus.rsp_rdata, exp_rd);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    if (we && !exp_err) ref_store(addr, size, wdata);
  endtask

  initial begin
    int          lat;
    logic [31:0] exp_rd;
    logic [31:0] a;
    logic [1:0]  sz;

    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    drive_req(1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
    bus.req_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("rst/req_ready", 32'(bus.req_ready), 32'd0);
    check("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst/rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst/rsp_err", 32'(bus.rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle/req_ready", 32'(bus.req_ready), 32'd1);

    // Seed the working window so every later read is defined.
    for (int w = 0; w < 128; w++) do_op("init", 1'b1, 32'(4 * w), 2'd2, 1'b0, $urandom);

    do_op("sw", 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
    do_op("lw", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    check("lw/plan", ref_load(32'h10, 2'd2, 1'b0), 32'hDEADBEEF);

    do_op("sw0", 1'b1, 32'h10, 2'd2, 1'b0, 32'h0);
    do_op("sb", 1'b1, 32'h13, 2'd0, 1'b0, 32'h80);
    do_op("lb", 1'b0, 32'h13, 2'd0, 1'b0, 32'h0);
    do_op("lbu", 1'b0, 32'h13, 2'd0, 1'b1, 32'h0);
    do_op("lw_b", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    check("lb/plan", ref_load(32'h13, 2'd0, 1'b0), 32'hFFFFFF80);
    check("lw_b/plan", ref_load(32'h10, 2'd2, 1'b0), 32'h80000000);

    do_op("sh", 1'b1, 32'h22, 2'd1, 1'b0, 32'h8001);
    do_op("lh", 1'b0, 32'h22, 2'd1, 1'b0, 32'h0);
    do_op("lhu", 1'b0, 32'h22, 2'd1, 1'b1, 32'h0);
    do_op("lh_lo", 1'b0, 32'h20, 2'd1, 1'b0, 32'h0);

    do_op("e_lw11", 1'b0, 32'h11, 2'd2, 1'b0, 32'h0);
    do_op("e_sh23", 1'b1, 32'h23, 2'd1, 1'b0, 32'h1234);
    do_op("e_sz3", 1'b1, 32'h20, 2'd3, 1'b0, 32'hFFFFFFFF);
    do_op("e_range", 1'b1, 32'(4 * Depth), 2'd2, 1'b0, 32'h55AA55AA);
    do_op("e_reread", 1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
    do_op("e_reread2", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);

    // Back-pressure: stall in RESP; a store presented meanwhile must be ignored.
    exp_rd = ref_load(32'h10, 2'd2, 1'b0);
    start_req("bp", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, lat);
    check("bp/lat", 32'(lat), 32'(ExpLat));
    for (int i = 0; i < 5; i++) begin
      check("bp/rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp/rsp_rdata", bus.rsp_rdata, exp_rd);
      check("bp/rsp_err", 32'(bus.rsp_err), 32'd0);
      check("bp/req_ready", 32'(bus.req_ready), 32'd0);
      drive_req(1'b1, 32'h40, 2'd2, 1'b0, 32'hBAD0BAD0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    do_op("bp/ignored", 1'b0, 32'h40, 2'd2, 1'b0, 32'h0);

    // Reset during an in-flight store.
`ifdef DMEM_WAIT_EN
    start_req("rst_mid", 1'b1, 32'h44, 2'd2, 1'b0, 32'hCAFEF00D, lat);
    check("rst_mid/lat", 32'(lat), 32'(ExpLat));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    ref_store(32'h44, 2'd2, 32'hCAFEF00D);
    @(negedge clk);
    drive_req(1'b1, 32'h48, 2'd2, 1'b0, 32'h12345678);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("rst_wait/rsp_valid", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end
    do_op("rst_wait/old", 1'b0, 32'h48, 2'd2, 1'b0, 32'h0);
    do_op("rst_wait/prev", 1'b0, 32'h44, 2'd2, 1'b0, 32'h0);
`else
    start_req("rst_resp", 1'b1, 32'h48, 2'd2, 1'b0, 32'h12345678, lat);
    check("rst_resp/lat", 32'(lat), 32'(ExpLat));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_store(32'h48, 2'd2, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      check("rst_resp/rsp_valid", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end
    do_op("rst_resp/kept", 1'b0, 32'h48, 2'd2, 1'b0, 32'h0);
`endif

    // Random mix of loads, stores and faults over the seeded window.
    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = 32'(4 * Depth) + $urandom_range(0, 4096);
      else a = 32'($urandom_range(0, 511));
      do_op("rnd", 1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
